gpu_column_fetcher: RTL and testbench
=====================================

# gpu_column_fetcher

Per-frame column-data fetcher between main memory and the raycast GPU scan-out path. At the start of each vertical blank it reads the bank-flag word, then copies 320 distance words and 320 texture words from the selected memory bank into a local column RAM. The GPU then indexes this RAM by column during active video, with no memory traffic in the visible region.

## Interface
Parameters:
- NUM_COLS, 320, columns per frame (one per 2 screen pixels)
- FLAG_ADDR, 16'hFFFE, bank-flag word; bit0 = bank select
- DIST_BASE_0, 16'hF800, bank 0 distance array
- TEX_BASE_0, 16'hF940, bank 0 texture array
- DIST_BASE_1, 16'hFA80, bank 1 distance array
- TEX_BASE_1, 16'hFBC0, bank 1 texture array

Ports:
- clk  in  1  pixel/system clock
- clr  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- mem_gnt  in  1  memory port grant
- read_data  in  16  memory read data; valid the cycle after an accepted address
- read_address  out  16  memory read address
- mem_req  out  1  memory port request
- col_index  in  9  column requested by the GPU
- col_distance  out  16  distance for col_index
- col_texture  out  16  texture for col_index
- busy  out  1  fetch in progress
- frame_valid  out  1  column RAM holds a complete frame
- overrun  out  1  sticky: frame_start arrived while busy

## Operation
- States: IDLE, FLAG, FLAG_WAIT, DIST, TEX, DRAIN.
- IDLE: on frame_start, go to FLAG and clear frame_valid.
- FLAG: mem_req=1, read_address=FLAG_ADDR. On grant, go to FLAG_WAIT.
- FLAG_WAIT: latch read_data[0] as bank, reset the column counter, go to DIST.
- DIST: read_address = DIST_BASE_bank + cnt. On each grant, cnt++. After the grant at cnt=NUM_COLS-1, go to TEX with cnt=0.
- TEX: same as DIST with TEX_BASE_bank. After the last grant, go to DRAIN.
- DRAIN: write the final returned word, set frame_valid, go to IDLE.
- Accepted transfer: mem_req and mem_gnt both high in the same cycle. While gnt is low, read_address and mem_req hold steady.
- Capture uses a one-bit pending flag plus a delayed index/type. Returned data is written to the distance or texture half of entry idx.
- Column RAM: 320 x 32 bits (distance in [31:16], texture in [15:0]). One write port, one registered read port.
- col_index >= NUM_COLS: col_distance and col_texture read 0 on the next cycle.
- frame_start while busy: ignored, the fetch continues, overrun set. overrun is cleared only by clr.
- Address arithmetic: 16-bit unsigned. Bases are chosen so base + 319 never wraps.

## Timing
- Reset values (clr low): state IDLE, read_address 0, mem_req 0, busy 0, frame_valid 0, overrun 0, col_distance 0, col_texture 0. RAM contents are undefined.
- Reset mid-fetch aborts immediately. The next frame_start after release starts a fresh fetch.
- Read port latency: col_index sampled at edge N produces col_distance/col_texture after edge N+1 (1 cycle).
- With mem_gnt held high and frame_start in cycle 0:
  - FLAG address in cycle 1.
  - Distance addresses in cycles 3–322.
  - Texture addresses in cycles 323–642.
  - busy high in cycles 1–643; frame_valid high from cycle 644.
- Each low-gnt cycle adds exactly one cycle of latency.
- The fetch must complete inside vertical blank (45 lines x 800 clocks = 36000 cycles). This allows heavy grant contention.

## Structure
- Shared package gpu_pkg holds:
  - NUM_COLS
  - all bank base addresses and FLAG_ADDR
  - the state enum
  - the column RAM depth/width
- Sub-module column_ram: simple dual-port, 320x32, with per-half write enables and a registered read port. It must infer block RAM.

## Test plan
- Bank 0, full grant: memory holds flag=0, dist[i]=i, tex[i]=0x1000+i; pulse frame_start. Required: busy falls cycle 643, frame_valid rises cycle 644. Reading col_index=5 gives 0x0005/0x1005 one cycle later.
- Bank 1: flag=1, dist at 0xFA80 holds 0xA000+i. Required: col_index=319 gives col_distance=0xA13F; read_address never falls in the bank-0 ranges.
- Grant stall: mem_gnt low for 10 cycles mid-DIST at cnt=100. Required: read_address holds 0xF864 for all 10 cycles, no entry is skipped or duplicated, and completion is delayed by exactly 10 cycles.
- Overrun: second frame_start at cycle 200. Required: the fetch completes unchanged and overrun=1 persists until clr.
- Reset mid-fetch: clr low at cycle 300, then a new frame_start. Required: all outputs return to their reset values immediately, and the fresh fetch completes with correct data.
- Out-of-range index: col_index=320 and 511. Required: outputs are 0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared definitions for the raycast column fetcher: geometry, memory map,
// sequencer state encoding and column RAM shape.
package gpu_pkg;

    localparam int          NUM_COLS    = 320;
    localparam logic [15:0] FLAG_ADDR   = 16'hFFFE;
    localparam logic [15:0] DIST_BASE_0 = 16'hF800;
    localparam logic [15:0] TEX_BASE_0  = 16'hF940;
    localparam logic [15:0] DIST_BASE_1 = 16'hFA80;
    localparam logic [15:0] TEX_BASE_1  = 16'hFBC0;

    // Column RAM: one entry per column, distance in the upper half, texture in the lower half
    localparam int RAM_DEPTH = NUM_COLS;
    localparam int RAM_WIDTH = 32;
    localparam int COL_AW    = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FLAG      = 3'd1,
        ST_FLAG_WAIT = 3'd2,
        ST_DIST      = 3'd3,
        ST_TEX       = 3'd4,
        ST_DRAIN     = 3'd5
    } fetch_state_t;

    // Pick the base address of an array according to the bank-select bit
    function automatic logic [15:0] bank_base(input logic bank,
                                              input logic [15:0] base0,
                                              input logic [15:0] base1);
        return bank ? base1 : base0;
    endfunction

endpackage

// File: rtl/gpu_column_fetcher_if.sv
// Main-memory read port used by the column fetcher. The fetcher is the
// master; the memory arbiter/controller is the slave.
interface gpu_column_fetcher_if;

    logic        mem_req;
    logic [15:0] read_address;
    logic        mem_gnt;
    logic [15:0] read_data;

    modport master (
        output mem_req,
        output read_address,
        input  mem_gnt,
        input  read_data
    );

    modport slave (
        input  mem_req,
        input  read_address,
        output mem_gnt,
        output read_data
    );

endinterface

// File: rtl/gpu_column_fetcher_column_ram.sv
// Simple dual-port column RAM: one write port with independent enables for
// the distance and texture halves, one registered read port. No reset on the
// storage or read register so that it maps onto block RAM.
module column_ram
    import gpu_pkg::*;
#(
    parameter int DEPTH = RAM_DEPTH,
    parameter int AW    = COL_AW
) (
    input  logic                 clk,
    input  logic                 we_hi,
    input  logic                 we_lo,
    input  logic [AW-1:0]        wr_addr,
    input  logic [RAM_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [RAM_WIDTH-1:0] rd_data
);

    localparam int HALF = RAM_WIDTH / 2;

    logic [RAM_WIDTH-1:0] mem_r [DEPTH];
    logic [RAM_WIDTH-1:0] rd_data_r;

    // Write port: each half of an entry is written independently
    always_ff @(posedge clk) begin
        if (we_hi) begin
            mem_r[wr_addr][RAM_WIDTH-1:HALF] <= wr_data[RAM_WIDTH-1:HALF];
        end
        if (we_lo) begin
            mem_r[wr_addr][HALF-1:0] <= wr_data[HALF-1:0];
        end
    end

    // Read port: one-cycle registered lookup
    always_ff @(posedge clk) begin
        rd_data_r <= mem_r[rd_addr];
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/gpu_column_fetcher.sv
// Per-frame column fetcher. At vertical blank it reads the bank flag, then
// copies the selected bank's distance and texture arrays into a local column
// RAM that the scan-out path indexes by column during active video.
module gpu_column_fetcher #(
    parameter int          NUM_COLS    = gpu_pkg::NUM_COLS,
    parameter logic [15:0] FLAG_ADDR   = gpu_pkg::FLAG_ADDR,
    parameter logic [15:0] DIST_BASE_0 = gpu_pkg::DIST_BASE_0,
    parameter logic [15:0] TEX_BASE_0  = gpu_pkg::TEX_BASE_0,
    parameter logic [15:0] DIST_BASE_1 = gpu_pkg::DIST_BASE_1,
    parameter logic [15:0] TEX_BASE_1  = gpu_pkg::TEX_BASE_1
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        frame_start,
    gpu_column_fetcher_if.master        bus,
    input  logic [8:0]                  col_index,
    output logic [15:0]                 col_distance,
    output logic [15:0]                 col_texture,
    output logic                        busy,
    output logic                        frame_valid,
    output logic                        overrun
);

    import gpu_pkg::*;

    localparam logic [8:0] LAST_COL  = 9'(NUM_COLS - 1);
    localparam logic [8:0] COL_LIMIT = 9'(NUM_COLS);

    fetch_state_t state_r;
    logic [15:0]  read_address_r;
    logic         mem_req_r;
    logic         busy_r;
    logic         frame_valid_r;
    logic         overrun_r;
    logic [8:0]   cnt_r;
    logic         bank_r;

    // Capture pipeline: the word for the transfer accepted last cycle arrives now
    logic         pend_r;
    logic [8:0]   pend_idx_r;
    logic         pend_tex_r;

    logic         accept_s;
    logic         we_dist_s;
    logic         we_tex_s;
    logic [31:0]  wr_data_s;
    logic         col_in_range_s;
    logic [8:0]   rd_addr_s;
    logic [31:0]  ram_q_s;
    logic         range_ok_r;

    assign accept_s = mem_req_r & bus.mem_gnt;

    // Fetch sequencer: state, request/address outputs, column counter, capture pipeline, status flags
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r        <= ST_IDLE;
            read_address_r <= 16'd0;
            mem_req_r      <= 1'b0;
            busy_r         <= 1'b0;
            frame_valid_r  <= 1'b0;
            overrun_r      <= 1'b0;
            cnt_r          <= 9'd0;
            bank_r         <= 1'b0;
            pend_r         <= 1'b0;
            pend_idx_r     <= 9'd0;
            pend_tex_r     <= 1'b0;
        end else begin
            pend_r <= 1'b0;
            // A new frame request while a fetch is still running is dropped but remembered
            if (frame_start && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_r        <= ST_FLAG;
                        mem_req_r      <= 1'b1;
                        read_address_r <= FLAG_ADDR;
                        busy_r         <= 1'b1;
                        frame_valid_r  <= 1'b0;
                    end
                end
                ST_FLAG: begin
                    if (accept_s) begin
                        state_r   <= ST_FLAG_WAIT;
                        mem_req_r <= 1'b0;
                    end
                end
                ST_FLAG_WAIT: begin
                    // Flag word is on read_data now; launch the first distance read immediately
                    bank_r         <= bus.read_data[0];
                    cnt_r          <= 9'd0;
                    state_r        <= ST_DIST;
                    mem_req_r      <= 1'b1;
                    read_address_r <= bank_base(bus.read_data[0], DIST_BASE_0, DIST_BASE_1);
                end
                ST_DIST: begin
                    if (accept_s) begin
                        pend_r     <= 1'b1;
                        pend_idx_r <= cnt_r;
                        pend_tex_r <= 1'b0;
                        if (cnt_r == LAST_COL) begin
                            cnt_r          <= 9'd0;
                            state_r        <= ST_TEX;
                            read_address_r <= bank_base(bank_r, TEX_BASE_0, TEX_BASE_1);
                        end else begin
                            cnt_r          <= cnt_r + 9'd1;
                            read_address_r <= read_address_r + 16'd1;
                        end
                    end
                end
                ST_TEX: begin
                    if (accept_s) begin
                        pend_r     <= 1'b1;
                        pend_idx_r <= cnt_r;
                        pend_tex_r <= 1'b1;
                        if (cnt_r == LAST_COL) begin
                            cnt_r     <= 9'd0;
                            state_r   <= ST_DRAIN;
                            mem_req_r <= 1'b0;
                        end else begin
                            cnt_r          <= cnt_r + 9'd1;
                            read_address_r <= read_address_r + 16'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Last texture word is written by the capture pipeline this cycle
                    state_r       <= ST_IDLE;
                    busy_r        <= 1'b0;
                    frame_valid_r <= 1'b1;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign we_dist_s = pend_r & ~pend_tex_r;
    assign we_tex_s  = pend_r & pend_tex_r;
    assign wr_data_s = {bus.read_data, bus.read_data};

    assign col_in_range_s = (col_index < COL_LIMIT);

    // Keep the RAM read address inside the array for out-of-range column requests
    always_comb begin
        rd_addr_s = 9'd0;
        if (col_in_range_s) begin
            rd_addr_s = col_index;
        end else begin
            rd_addr_s = 9'd0;
        end
    end

    // Track whether the lookup now in the RAM read register was for a real column
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            range_ok_r <= 1'b0;
        end else begin
            range_ok_r <= col_in_range_s;
        end
    end

    column_ram #(
        .DEPTH (RAM_DEPTH),
        .AW    (COL_AW)
    ) u_column_ram (
        .clk     (clk),
        .we_hi   (we_dist_s),
        .we_lo   (we_tex_s),
        .wr_addr (pend_idx_r),
        .wr_data (wr_data_s),
        .rd_addr (rd_addr_s),
        .rd_data (ram_q_s)
    );

    // Out-of-range lookups and the reset state read as zero
    always_comb begin
        col_distance = 16'd0;
        col_texture  = 16'd0;
        if (range_ok_r) begin
            col_distance = ram_q_s[31:16];
            col_texture  = ram_q_s[15:0];
        end else begin
            col_distance = 16'd0;
            col_texture  = 16'd0;
        end
    end

    assign bus.mem_req      = mem_req_r;
    assign bus.read_address = read_address_r;
    assign busy             = busy_r;
    assign frame_valid      = frame_valid_r;
    assign overrun          = overrun_r;

endmodule

// File: tb/tb_gpu_column_fetcher.sv
// Scoreboard bench for gpu_column_fetcher: a memory responder with
// controllable grant, a reference model that derives the expected address
// stream and column contents from memory, and a monitor that checks every
// accepted transfer and every column lookup against queued expectations.
module tb_gpu_column_fetcher;

    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic        frame_start;
    logic [8:0]  col_index;
    logic [15:0] col_distance;
    logic [15:0] col_texture;
    logic        busy;
    logic        frame_valid;
    logic        overrun;

    gpu_column_fetcher_if bus ();

    gpu_column_fetcher dut (
        .clk          (clk),
        .clr          (clr),
        .frame_start  (frame_start),
        .bus          (bus),
        .col_index    (col_index),
        .col_distance (col_distance),
        .col_texture  (col_texture),
        .busy         (busy),
        .frame_valid  (frame_valid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Reference memory and expected column contents
    logic [15:0] mem [0:65535];
    logic [15:0] exp_dist [NUM_COLS];
    logic [15:0] exp_tex  [NUM_COLS];
    logic [15:0] addr_q [$];
    logic [31:0] col_q [$];

    int n_checks = 0;
    int n_errors = 0;

    // Responder controls and statistics
    int          gnt_mode = 0;
    int          low_req_cycles = 0;
    int          bank0_hits = 0;
    int          hold_bad = 0;
    int          stall_req = 0;
    int          stall_done = 0;
    int          stall_left = 0;
    logic [15:0] stall_addr = 16'hF864;
    logic        pend_v = 1'b0;
    logic [15:0] pend_a = 16'd0;
    logic        gnt_s;

    // Monitor state
    int          rd_issued = 0;
    int          rd_taken = 0;
    bit          cmp_next = 1'b0;
    bit          held_v = 1'b0;
    logic [15:0] held_a = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Memory slave: grant policy and one-cycle read data
    always begin
        @(negedge clk);
        bus.read_data = pend_v ? mem[pend_a] : 16'($urandom);
        if ((stall_req != stall_done) && bus.mem_req && (bus.read_address == stall_addr)) begin
            stall_left = 10;
            stall_done = stall_req;
        end
        if (stall_left > 0) begin
            gnt_s = 1'b0;
            stall_left--;
            if (!bus.mem_req || (bus.read_address != stall_addr)) hold_bad++;
        end else if (gnt_mode != 0) begin
            gnt_s = ($urandom_range(0, 3) != 0);
        end else begin
            gnt_s = 1'b1;
        end
        bus.mem_gnt = gnt_s;
        pend_v = bus.mem_req && gnt_s && clr;
        pend_a = bus.read_address;
        if (clr && bus.mem_req && !gnt_s) low_req_cycles++;
        if (pend_v && (pend_a >= DIST_BASE_0) && (pend_a < DIST_BASE_1)) bank0_hits++;
    end

    // Monitor: checks accepted addresses, hold-while-stalled, and column lookups
    always begin
        @(negedge clk);
        #2;
        if (!clr) begin
            addr_q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("addr_hold", {15'd0, bus.mem_req, bus.read_address}, {15'd0, 1'b1, held_a});
            end
            held_v = bus.mem_req && !bus.mem_gnt;
            held_a = bus.read_address;
            if (bus.mem_req && bus.mem_gnt) begin
                check("addr_expected", 32'(addr_q.size() != 0), 32'd1);
                if (addr_q.size() != 0) begin
                    check("addr", {16'd0, bus.read_address}, {16'd0, addr_q.pop_front()});
                end
            end
        end
        if (cmp_next) begin
            check("col_expected", 32'(col_q.size() != 0), 32'd1);
            if (col_q.size() != 0) begin
                check("column", {col_distance, col_texture}, col_q.pop_front());
            end
        end
        cmp_next = (rd_issued != rd_taken);
        rd_taken = rd_issued;
    end

    task automatic check_reset(input string pfx);
        check({pfx, "_addr"}, {16'd0, bus.read_address}, 32'd0);
        check({pfx, "_ctl"}, {28'd0, bus.mem_req, busy, frame_valid, overrun}, 32'd0);
        check({pfx, "_col"}, {col_distance, col_texture}, 32'd0);
    endtask

    // Fill the chosen bank (pattern or random), scribble the other bank
    task automatic fill(input logic bank, input bit rnd, input logic [15:0] d0, input logic [15:0] t0);
        logic [15:0] db;
        logic [15:0] tb_base;
        logic [15:0] odb;
        logic [15:0] otb;
        mem[FLAG_ADDR] = {15'($urandom), bank};
        db      = bank ? DIST_BASE_1 : DIST_BASE_0;
        tb_base = bank ? TEX_BASE_1  : TEX_BASE_0;
        odb     = bank ? DIST_BASE_0 : DIST_BASE_1;
        otb     = bank ? TEX_BASE_0  : TEX_BASE_1;
        for (int i = 0; i < NUM_COLS; i++) begin
            mem[db + 16'(i)]      = rnd ? 16'($urandom) : d0 + 16'(i);
            mem[tb_base + 16'(i)] = rnd ? 16'($urandom) : t0 + 16'(i);
            mem[odb + 16'(i)]     = 16'($urandom);
            mem[otb + 16'(i)]     = 16'($urandom);
        end
    endtask

    // Reference model: expected transfer stream and resulting column table
    task automatic push_frame();
        logic        bank;
        logic [15:0] db;
        logic [15:0] tb_base;
        bank    = mem[FLAG_ADDR][0];
        db      = bank ? DIST_BASE_1 : DIST_BASE_0;
        tb_base = bank ? TEX_BASE_1  : TEX_BASE_0;
        addr_q.push_back(FLAG_ADDR);
        for (int i = 0; i < NUM_COLS; i++) begin
            addr_q.push_back(db + 16'(i));
            exp_dist[i] = mem[db + 16'(i)];
        end
        for (int i = 0; i < NUM_COLS; i++) begin
            addr_q.push_back(tb_base + 16'(i));
            exp_tex[i] = mem[tb_base + 16'(i)];
        end
    endtask

    // One frame fetch; frame_start is high in cycle 0
    task automatic run_frame(input int second_at, input bit exact, output int fv_cycle, output int lr);
        int          cyc;
        int          last_busy;
        int          low0;
        logic [15:0] dbase;
        push_frame();
        dbase = mem[FLAG_ADDR][0] ? DIST_BASE_1 : DIST_BASE_0;
        @(negedge clk);
        low0 = low_req_cycles;
        frame_start = 1'b1;
        cyc = 0;
        last_busy = -1;
        fv_cycle = -1;
        while ((fv_cycle < 0) && (cyc < 5000)) begin
            @(negedge clk);
            cyc++;
            frame_start = (cyc == second_at);
            if (cyc == 1) begin
                check("busy_rise", {31'd0, busy}, 32'd1);
                check("fv_cleared", {31'd0, frame_valid}, 32'd0);
            end
            if (exact && (cyc == 1)) check("flag_cycle1", {15'd0, bus.mem_req, bus.read_address}, {15'd0, 1'b1, FLAG_ADDR});
            if (exact && (cyc == 3)) check("dist_cycle3", {15'd0, bus.mem_req, bus.read_address}, {15'd0, 1'b1, dbase});
            if (busy) last_busy = cyc;
            if (frame_valid) fv_cycle = cyc;
        end
        frame_start = 1'b0;
        lr = low_req_cycles - low0;
        check("fv_cycle", 32'(fv_cycle), 32'(644 + lr));
        check("busy_last", 32'(last_busy), 32'(fv_cycle - 1));
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
    endtask

    task automatic read_col(input int idx);
        @(negedge clk);
        col_index = 9'(idx);
        if (idx < NUM_COLS) col_q.push_back({exp_dist[idx], exp_tex[idx]});
        else                col_q.push_back(32'd0);
        rd_issued++;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        check("col_q_drained", 32'(col_q.size()), 32'd0);
    endtask

    task automatic read_some();
        read_col(5);
        read_col(0);
        read_col(319);
        read_col(320);
        read_col(511);
        for (int k = 0; k < 6; k++) read_col(int'($urandom_range(0, 319)));
        settle();
    endtask

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "time limit");
    end

    // Stimulus sequence
    initial begin
        int fv;
        int lr;
        int b0;
        clr = 1'b0;
        frame_start = 1'b0;
        col_index = 9'd0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        @(negedge clk);
        clr = 1'b1;

        // Bank 0, full grant, ramp pattern
        gnt_mode = 0;
        fill(1'b0, 1'b0, 16'h0000, 16'h1000);
        run_frame(-1, 1'b1, fv, lr);
        check("b0_fv", 32'(fv), 32'd644);
        check("b0_overrun", {31'd0, overrun}, 32'd0);
        read_some();

        // Bank 1, full grant; no bank-0 traffic allowed
        fill(1'b1, 1'b0, 16'hA000, 16'hB000);
        b0 = bank0_hits;
        run_frame(-1, 1'b1, fv, lr);
        check("b1_fv", 32'(fv), 32'd644);
        check("b1_no_bank0", 32'(bank0_hits - b0), 32'd0);
        read_some();

        // Ten-cycle grant stall at distance column 100
        fill(1'b0, 1'b0, 16'h0000, 16'h1000);
        b0 = hold_bad;
        stall_req++;
        run_frame(-1, 1'b1, fv, lr);
        check("stall_fv", 32'(fv), 32'd654);
        check("stall_low_cycles", 32'(lr), 32'd10);
        check("stall_hold", 32'(hold_bad - b0), 32'd0);
        read_col(99);
        read_col(100);
        read_col(101);
        settle();

        // Overrun: second frame_start at cycle 200 is ignored
        fill(1'b1, 1'b1, 16'h0000, 16'h0000);
        run_frame(200, 1'b1, fv, lr);
        check("ovr_fv", 32'(fv), 32'd644);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        read_some();

        // Random grant; overrun must persist
        gnt_mode = 1;
        fill(1'b0, 1'b1, 16'h0000, 16'h0000);
        run_frame(-1, 1'b0, fv, lr);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        read_some();

        // Reset mid-fetch at cycle 300
        fill(1'b1, 1'b1, 16'h0000, 16'h0000);
        push_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (299) @(negedge clk);
        clr = 1'b0;
        #1;
        check_reset("midreset");
        repeat (3) @(negedge clk);
        clr = 1'b1;

        // Fresh fetch after reset, random data and grant, full table readback
        fill(1'b1, 1'b1, 16'h0000, 16'h0000);
        run_frame(-1, 1'b0, fv, lr);
        check("post_reset_overrun", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < NUM_COLS; i++) read_col(i);
        read_col(320);
        read_col(511);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
